// File: rtl/centroid_mux_seq.sv
// rtl/centroid_mux_seq.sv - N-channel registered selector with single/sweep modes and valid/ready handshakes
module centroid_mux_seq #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 6,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] in_flat,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_mode,
    input  logic [SEL_W-1:0]         req_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     out_err,
    output logic                     busy
);

    localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CH - 1);

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [SEL_W-1:0]    r_idx;
    logic                r_last;
    logic                r_err;
    logic                r_mode;

    logic                w_accept;
    logic                w_advance;
    logic                w_load;
    logic                w_load_mode;
    logic [SEL_W-1:0]    w_load_idx;
    logic                w_load_err;
    logic                w_load_last;
    logic [DATA_W-1:0]   w_ch_data;

    assign w_accept  = req_valid & req_ready;
    assign w_advance = out_valid & out_ready & ~r_last;
    assign w_load    = w_accept | w_advance;

    // One shared load path: a fresh request in IDLE, or the next sweep beat in EMIT.
    assign w_load_mode = (r_state == S_IDLE) ? req_mode : r_mode;
    assign w_load_idx  = (r_state == S_IDLE) ? (req_mode ? '0 : req_sel)
                                             : r_idx + SEL_W'(1);
    assign w_load_err  = ~w_load_mode & ({1'b0, w_load_idx} >= NUM_CH_W);
    assign w_load_last = ~w_load_mode | (w_load_idx == LAST_IDX);

    // Indices with no matching channel fall through to zero data.
    always_comb begin
        w_ch_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_load_idx == SEL_W'(k)) begin
                w_ch_data = in_flat[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EMIT;
            S_EMIT:  if (out_ready && r_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        out_valid = (r_state == S_EMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
            r_idx  <= '0;
            r_last <= 1'b0;
            r_err  <= 1'b0;
            r_mode <= 1'b0;
        end else begin
            if (w_load) begin
                r_data <= w_ch_data;
                r_idx  <= w_load_idx;
                r_last <= w_load_last;
                r_err  <= w_load_err;
            end
            if (w_accept) begin
                r_mode <= req_mode;
            end
        end
    end

    assign out_data = r_data;
    assign out_idx  = r_idx;
    assign out_last = r_last;
    assign out_err  = r_err;

endmodule

// File: tb/tb_centroid_mux_seq.sv
// tb/tb_centroid_mux_seq.sv - self-checking bench for centroid_mux_seq with a behavioural beat model
module tb_centroid_mux_seq;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 6;
    localparam int SEL_W  = 2;
    localparam int FW     = NUM_CH * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [FW-1:0]     in_flat;
    logic              req_valid;
    logic              req_ready;
    logic              req_mode;
    logic [SEL_W-1:0]  req_sel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [SEL_W-1:0]  out_idx;
    logic              out_last;
    logic              out_err;
    logic              busy;

    logic [12:0]       obs;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    centroid_mux_seq #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_flat(in_flat),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_sel(req_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .out_err(out_err), .busy(busy)
    );

    assign obs = {out_valid, out_data, out_idx, out_last, out_err, busy, req_ready};

    // Expected {valid,data,idx,last,err} for beat k of a request, given channel values at its load edge.
    function automatic logic [10:0] exp_beat(input logic mode, input int sel, input int k,
                                             input logic [FW-1:0] f);
        int ch[NUM_CH];
        int d, idx;
        logic last, err;
        for (int c = 0; c < NUM_CH; c++) ch[c] = int'((f >> (c * DATA_W)) & ((1 << DATA_W) - 1));
        if (!mode) begin
            idx  = sel;
            last = 1'b1;
            err  = (sel >= NUM_CH);
            d    = err ? 0 : ch[sel];
        end else begin
            idx  = k;
            last = (k == NUM_CH - 1);
            err  = 1'b0;
            d    = ch[k];
        end
        return {1'b1, 6'(d), 2'(idx), last, err};
    endfunction

    task automatic send_req(input logic mode, input int sel);
        int n = 0;
        req_mode  = mode;
        req_sel   = 2'(sel);
        req_valid = 1'b1;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_req: req_ready got %b expected 1 within 10 cycles", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_mode  = 1'b0;
        req_sel   = 2'd1;
        in_flat   = FW'($urandom());
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 13'b0_000000_00_0_0_0_1) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", obs, 13'b0_000000_00_0_0_0_1);
        end
        rst_n     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 13'b0_000000_00_0_0_0_1) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obs, 13'b0_000000_00_0_0_0_1);
        end
    endtask

    task automatic test_single;
        in_flat   = {6'd40, 6'd21, 6'd7};
        out_ready = 1'b1;
        send_req(1'b0, 1);
        checks++;
        if (obs !== {1'b1, 6'd21, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_beat: got %h expected %h", obs, {1'b1, 6'd21, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, busy, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL single_idle: got %b expected 001", {out_valid, busy, req_ready});
        end
    endtask

    task automatic test_out_of_range;
        in_flat   = {6'd40, 6'd21, 6'd7};
        out_ready = 1'b1;
        send_req(1'b0, 3);
        checks++;
        if (obs !== {1'b1, 6'd0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL oor_beat: got %h expected %h", obs, {1'b1, 6'd0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, busy, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL oor_idle: got %b expected 001", {out_valid, busy, req_ready});
        end
    endtask

    task automatic test_sweep;
        in_flat   = {6'd40, 6'd21, 6'd7};
        out_ready = 1'b1;
        send_req(1'b1, int'($urandom_range(0, 3)));
        for (int k = 0; k < NUM_CH; k++) begin
            checks++;
            if (obs !== {exp_beat(1'b1, 0, k, in_flat), 2'b10}) begin
                errors++;
                $display("FAIL sweep_beat%0d: got %h expected %h", k, obs, {exp_beat(1'b1, 0, k, in_flat), 2'b10});
            end
            @(negedge clk);
        end
        checks++;
        if ({out_valid, busy, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL sweep_idle: got %b expected 001", {out_valid, busy, req_ready});
        end
    endtask

    task automatic test_backpressure;
        in_flat   = {6'd40, 6'd21, 6'd7};
        out_ready = 1'b1;
        send_req(1'b1, 2);
        checks++;
        if (obs !== {1'b1, 6'd7, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL bp_beat0: got %h expected %h", obs, {1'b1, 6'd7, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== {1'b1, 6'd21, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d: got %h expected %h", i, obs, {1'b1, 6'd21, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0});
            end
            in_flat = FW'($urandom());
            @(negedge clk);
        end
        in_flat   = {6'd40, 6'd21, 6'd7};
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 6'd40, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL bp_beat2: got %h expected %h", obs, {1'b1, 6'd40, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, busy, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL bp_idle: got %b expected 001", {out_valid, busy, req_ready});
        end
    endtask

    task automatic test_reset_mid;
        in_flat   = {6'd40, 6'd21, 6'd7};
        out_ready = 1'b1;
        send_req(1'b1, 0);
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 6'd21, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_beat1: got %h expected %h", obs, {1'b1, 6'd21, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (obs !== 13'b0_000000_00_0_0_0_1) begin
            errors++;
            $display("FAIL mid_reset: got %h expected %h", obs, 13'b0_000000_00_0_0_0_1);
        end
        send_req(1'b0, 2);
        checks++;
        if (obs !== {1'b1, 6'd40, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_after: got %h expected %h", obs, {1'b1, 6'd40, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        @(negedge clk);
    endtask

    // Random requests back to back, random backpressure, channel values changing every cycle.
    task automatic test_random;
        logic          mode;
        int            sel, k, nbeats, cyc;
        logic          rdy, done;
        logic [FW-1:0] f, nf;
        for (int r = 0; r < 40; r++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = int'($urandom_range(0, 3));
            req_mode  = mode;
            req_sel   = 2'(sel);
            req_valid = 1'b1;
            in_flat   = FW'($urandom());
            f         = in_flat;
            checks++;
            if ({out_valid, busy, req_ready} !== 3'b001) begin
                errors++;
                $display("FAIL rand_idle%0d: got %b expected 001", r, {out_valid, busy, req_ready});
            end
            @(negedge clk);
            req_valid = 1'($urandom_range(0, 1));
            req_mode  = ~mode;
            req_sel   = 2'($urandom());
            k         = 0;
            nbeats    = mode ? NUM_CH : 1;
            done      = 1'b0;
            cyc       = 0;
            while (!done && cyc < 40) begin
                checks++;
                if (obs !== {exp_beat(mode, sel, k, f), 2'b10}) begin
                    errors++;
                    $display("FAIL rand_beat r%0d k%0d: got %h expected %h", r, k, obs, {exp_beat(mode, sel, k, f), 2'b10});
                end
                rdy       = 1'($urandom_range(0, 1));
                out_ready = rdy;
                nf        = FW'($urandom());
                in_flat   = nf;
                @(negedge clk);
                if (rdy) begin
                    k++;
                    f = nf;
                    if (k == nbeats) done = 1'b1;
                end
                req_valid = 1'($urandom_range(0, 1));
                cyc++;
            end
            req_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_out_of_range();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
